// File: rtl/stack_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_engine_pkg
// Description : Shared op codes, FSM state encodings and stack bound defaults
//               for the stack engine and its bounds checker.
// Revision    : 1.0 - initial release
// ============================================================================
package stack_engine_pkg;

  typedef logic [1:0] op_code_t;

  localparam op_code_t OP_PUSH16 = 2'd0;
  localparam op_code_t OP_POP16  = 2'd1;
  localparam op_code_t OP_PUSH32 = 2'd2;
  localparam op_code_t OP_POP32  = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_HI   = 3'd1;
  localparam logic [2:0] S_WR_LO   = 3'd2;
  localparam logic [2:0] S_RD_LO   = 3'd3;
  localparam logic [2:0] S_RD_HI   = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int STACK_TOP_DEFAULT  = 2047;
  localparam int STACK_BASE_DEFAULT = 1024;

endpackage : stack_engine_pkg
`default_nettype wire

// File: rtl/stack_engine_bounds_check.sv
`default_nettype none
// ============================================================================
// Module      : stack_engine_bounds_check
// Description : Combinational overflow/underflow check of a stack operation
//               against the current SP. Shared with the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_engine_bounds_check
  import stack_engine_pkg::*;
#(
  parameter int STACK_TOP  = STACK_TOP_DEFAULT,
  parameter int STACK_BASE = STACK_BASE_DEFAULT
) (
  input  logic [1:0]  op_code_i,
  input  logic [31:0] sp_i,
  output logic        err_o
);

  // Pops compare in 33 bits so sp+1/sp+2 can never wrap to a small value.
  logic [32:0] w_sp_ext;
  assign w_sp_ext = {1'b0, sp_i};

  // Pushes must stay at or above STACK_BASE, pops may not read above STACK_TOP.
  always_comb begin
    err_o = 1'b0;
    case (op_code_i)
      OP_PUSH16: err_o = (sp_i < 32'(STACK_BASE));
      OP_PUSH32: err_o = (sp_i < 32'(STACK_BASE + 1));
      OP_POP16:  err_o = ((w_sp_ext + 33'd1) > 33'(STACK_TOP));
      OP_POP32:  err_o = ((w_sp_ext + 33'd2) > 33'(STACK_TOP));
      default:   err_o = 1'b0;
    endcase
  end

endmodule : stack_engine_bounds_check
`default_nettype wire

// File: rtl/stack_engine.sv
`default_nettype none
// ============================================================================
// Module      : stack_engine
// Description : Moore FSM sequencing PUSH/POP, CALL/RET and INT/RTI traffic
//               between the SP register and the 16-bit data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_engine
  import stack_engine_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int STACK_TOP  = STACK_TOP_DEFAULT,
  parameter int STACK_BASE = STACK_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic [31:0]       op_data,
  output logic              op_ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       result_data,
  output logic              stall,
  input  logic [31:0]       sp_read_data,
  output logic [31:0]       sp_write_data,
  output logic              sp_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [15:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] C_A1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_A2 = ADDR_W'(2);

  logic [2:0]  state_q, state_d;
  op_code_t    code_q;
  logic [31:0] data_q;
  logic [31:0] sp_q;
  logic [31:0] result_q;
  logic        err_q;
  logic        w_accept;
  logic        w_bounds_err;

  assign w_accept = op_valid && (state_q == S_IDLE);

  // The SP sampled at accept is the one latched, so checking it directly is
  // equivalent to checking the latched copy.
  stack_engine_bounds_check #(
    .STACK_TOP  (STACK_TOP),
    .STACK_BASE (STACK_BASE)
  ) u_bounds (
    .op_code_i (op_code),
    .sp_i      (sp_read_data),
    .err_o     (w_bounds_err)
  );

  // State register, request latches and popped-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      code_q   <= OP_PUSH16;
      data_q   <= '0;
      sp_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        code_q   <= op_code;
        data_q   <= op_data;
        sp_q     <= sp_read_data;
        err_q    <= w_bounds_err;
        result_q <= '0;
      end
      if (state_q == S_RD_HI) begin
        result_q[15:0] <= mem_rdata;
      end
      if (state_q == S_RD_WAIT) begin
        if (code_q == OP_POP16) begin
          result_q <= {16'd0, mem_rdata};
        end else begin
          result_q[31:16] <= mem_rdata;
        end
      end
    end
  end

  // Next-state sequencing; an out-of-bounds request skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_bounds_err)            state_d = S_DONE;
          else if (op_code == OP_PUSH16) state_d = S_WR_LO;
          else if (op_code == OP_PUSH32) state_d = S_WR_HI;
          else                           state_d = S_RD_LO;
        end
      end
      S_WR_HI:   state_d = S_WR_LO;
      S_WR_LO:   state_d = S_DONE;
      S_RD_LO:   state_d = (code_q == OP_POP32) ? S_RD_HI : S_RD_WAIT;
      S_RD_HI:   state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore output decode from state and latched request.
  always_comb begin
    op_ready        = (state_q == S_IDLE);
    stall           = (state_q != S_IDLE);
    done            = (state_q == S_DONE);
    err             = (state_q == S_DONE) && err_q;
    sp_write_enable = (state_q == S_DONE) && !err_q;
    result_data     = (state_q == S_DONE) ? result_q : 32'd0;
    sp_write_data   = 32'd0;
    mem_addr        = '0;
    mem_wdata       = 16'd0;
    mem_write       = 1'b0;
    mem_read        = 1'b0;
    case (state_q)
      S_WR_HI: begin
        mem_write = 1'b1;
        mem_addr  = sp_q[ADDR_W-1:0];
        mem_wdata = data_q[31:16];
      end
      S_WR_LO: begin
        mem_write = 1'b1;
        mem_addr  = (code_q == OP_PUSH32) ? (sp_q[ADDR_W-1:0] - C_A1) : sp_q[ADDR_W-1:0];
        mem_wdata = data_q[15:0];
      end
      S_RD_LO: begin
        mem_read = 1'b1;
        mem_addr = sp_q[ADDR_W-1:0] + C_A1;
      end
      S_RD_HI: begin
        mem_read = 1'b1;
        mem_addr = sp_q[ADDR_W-1:0] + C_A2;
      end
      S_DONE: begin
        if (!err_q) begin
          case (code_q)
            OP_PUSH16: sp_write_data = sp_q - 32'd1;
            OP_PUSH32: sp_write_data = sp_q - 32'd2;
            OP_POP16:  sp_write_data = sp_q + 32'd1;
            default:   sp_write_data = sp_q + 32'd2;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule : stack_engine
`default_nettype wire

// File: tb/tb_stack_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_engine
// Description : Self-checking bench for stack_engine with an SP register and
//               16-bit memory model around it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_engine;
  import stack_engine_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_data;
  logic        op_ready, done, err, stall;
  logic [31:0] result_data, sp_write_data, sp_read_data;
  logic        sp_write_enable;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int checks = 0;
  int errors = 0;

  stack_engine #(.ADDR_W(11), .STACK_TOP(2047), .STACK_BASE(1024)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_data(op_data), .op_ready(op_ready), .done(done), .err(err),
    .result_data(result_data), .stall(stall), .sp_read_data(sp_read_data),
    .sp_write_data(sp_write_data), .sp_write_enable(sp_write_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SP register model with a bench-only preset path to reach the bounds.
  logic        preset_en = 1'b0;
  logic [31:0] preset_val = 32'd0;
  logic [31:0] sp_reg;
  always @(posedge clk) begin
    if (!reset)               sp_reg <= 32'd2047;
    else if (preset_en)       sp_reg <= preset_val;
    else if (sp_write_enable) sp_reg <= sp_write_data;
  end
  assign sp_read_data = sp_reg;

  // Data memory model with 1-cycle read latency.
  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [1:0]  code;
    logic [31:0] data;
    int          preset;   // -1: keep current SP
    logic        exp_err;
    logic [31:0] exp_res;
    logic [31:0] exp_sp;
    int          exp_lat;
    int          exp_wr;
    int          exp_rd;
    int          mchk_addr; // -1: no memory check
    logic [15:0] mchk_val;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] c, input logic [31:0] d, input int p,
                              input logic e, input logic [31:0] r, input logic [31:0] s,
                              input int l, input int w, input int rd, input int ma,
                              input logic [15:0] mv);
    vec_t v;
    v.code = c; v.data = d; v.preset = p; v.exp_err = e; v.exp_res = r;
    v.exp_sp = s; v.exp_lat = l; v.exp_wr = w; v.exp_rd = rd;
    v.mchk_addr = ma; v.mchk_val = mv;
    return v;
  endfunction

  task automatic do_preset(input int v);
    @(negedge clk);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int wr, rd, lat;
    logic got, stall_ok, d_err, d_we;
    logic [31:0] d_res, d_wd;
    if (v.preset >= 0) do_preset(v.preset);
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), op_ready, 1);
    op_valid = 1'b1; op_code = v.code; op_data = v.data;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op_code = ~v.code; op_data = 32'h0;
    wr = 0; rd = 0; lat = 0; got = 1'b0; stall_ok = 1'b1;
    d_err = 1'b0; d_we = 1'b0; d_res = 32'd0; d_wd = 32'd0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      wr += int'(mem_write);
      rd += int'(mem_read);
      if (!stall) stall_ok = 1'b0;
      if (done) begin
        got = 1'b1; lat = n; d_err = err; d_res = result_data;
        d_we = sp_write_enable; d_wd = sp_write_data;
      end
    end
    chk($sformatf("v%0d_done_seen", idx), got, 1);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_err", idx), d_err, v.exp_err);
    chk($sformatf("v%0d_sp_we", idx), d_we, !v.exp_err);
    if (!v.exp_err) chk($sformatf("v%0d_sp_wdata", idx), d_wd, v.exp_sp);
    if (v.exp_err || v.code == OP_POP16 || v.code == OP_POP32)
      chk($sformatf("v%0d_result", idx), d_res, v.exp_res);
    chk($sformatf("v%0d_writes", idx), wr, v.exp_wr);
    chk($sformatf("v%0d_reads", idx), rd, v.exp_rd);
    chk($sformatf("v%0d_stall", idx), stall_ok, 1);
    @(negedge clk);
    chk($sformatf("v%0d_sp_after", idx), sp_reg, v.exp_sp);
    chk($sformatf("v%0d_ready_after", idx), op_ready, 1);
    if (v.mchk_addr >= 0)
      chk($sformatf("v%0d_mem", idx), mem[v.mchk_addr], v.mchk_val);
  endtask

  initial begin
    logic [3:0]  ready_seq, stall_seq;
    logic [31:0] wd_seen;
    logic        got;
    int          lat;
    logic [31:0] res2;
    logic        we_seen;

    //               code       data          preset err res           sp    lat wr rd  maddr mval
    vecs[0]  = mk(OP_PUSH32, 32'hDEADBEEF, 2047, 0, 32'h0,        2045, 3, 2, 0, 2047, 16'hDEAD);
    vecs[1]  = mk(OP_POP32,  32'h0,        -1,   0, 32'hDEADBEEF, 2047, 4, 0, 2, 2046, 16'hBEEF);
    vecs[2]  = mk(OP_POP16,  32'h0,        -1,   1, 32'h0,        2047, 1, 0, 0, -1,   16'h0);
    vecs[3]  = mk(OP_POP32,  32'h0,        -1,   1, 32'h0,        2047, 1, 0, 0, -1,   16'h0);
    vecs[4]  = mk(OP_PUSH16, 32'h00005A5A, -1,   0, 32'h0,        2046, 2, 1, 0, 2047, 16'h5A5A);
    vecs[5]  = mk(OP_POP16,  32'h0,        -1,   0, 32'h00005A5A, 2047, 3, 0, 1, -1,   16'h0);
    vecs[6]  = mk(OP_PUSH32, 32'h11112222, -1,   0, 32'h0,        2045, 3, 2, 0, 2046, 16'h2222);
    vecs[7]  = mk(OP_POP16,  32'h0,        -1,   0, 32'h00002222, 2046, 3, 0, 1, -1,   16'h0);
    vecs[8]  = mk(OP_POP32,  32'h0,        -1,   1, 32'h0,        2046, 1, 0, 0, -1,   16'h0);
    vecs[9]  = mk(OP_POP16,  32'h0,        -1,   0, 32'h00001111, 2047, 3, 0, 1, -1,   16'h0);
    vecs[10] = mk(OP_PUSH16, 32'hFFFF1234, 1024, 0, 32'h0,        1023, 2, 1, 0, 1024, 16'h1234);
    vecs[11] = mk(OP_PUSH16, 32'h0000ABCD, -1,   1, 32'h0,        1023, 1, 0, 0, 1024, 16'h1234);
    vecs[12] = mk(OP_PUSH32, 32'hAAAA5555, 1025, 0, 32'h0,        1023, 3, 2, 0, 1025, 16'hAAAA);
    vecs[13] = mk(OP_PUSH32, 32'h77778888, 1024, 1, 32'h0,        1024, 1, 0, 0, 1024, 16'h5555);
    vecs[14] = mk(OP_POP16,  32'h0,        1023, 0, 32'h00005555, 1024, 3, 0, 1, -1,   16'h0);
    vecs[15] = mk(OP_POP32,  32'h0,        1023, 0, 32'hAAAA5555, 1025, 4, 0, 2, -1,   16'h0);

    reset = 1'b0; op_valid = 1'b0; op_code = 2'd0; op_data = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", op_ready, 1);
    chk("reset_strobes", {done, err, mem_write, mem_read, sp_write_enable, stall}, 6'b0);
    chk("reset_result", result_data, 0);
    chk("reset_sp", sp_reg, 2047);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Held op_valid across PUSH32; op_code switched to POP16 while busy.
    do_preset(2047);
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_PUSH32; op_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    op_code = OP_POP16;
    ready_seq = 4'b0; stall_seq = 4'b0; wd_seen = 32'd0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      ready_seq[3-n] = op_ready;
      stall_seq[3-n] = stall;
      if (done) wd_seen = sp_write_data;
    end
    chk("hold_ready_seq", ready_seq, 4'b0001);
    chk("hold_stall_seq", stall_seq, 4'b1110);
    chk("hold_push_sp", wd_seen, 2045);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    got = 1'b0; lat = 0; res2 = 32'd0;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; lat = n; res2 = result_data; end
    end
    chk("hold_second_done", got, 1);
    chk("hold_second_lat", lat, 3);
    chk("hold_second_result", res2, 32'h0000F00D);
    @(negedge clk);
    chk("hold_second_sp", sp_reg, 2046);

    // Reset asserted during WR_LO of a PUSH32.
    do_preset(2047);
    @(negedge clk);
    op_valid = 1'b1; op_code = OP_PUSH32; op_data = 32'h0BAD1DEA;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_wrlo_addr", mem_addr, 2046);
    chk("rst_mid_wrlo_write", mem_write, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", op_ready, 1);
    chk("rst_mid_strobes", {done, err, mem_write, mem_read, sp_write_enable}, 5'b0);
    chk("rst_mid_buses", {mem_addr, mem_wdata}, 0);
    chk("rst_mid_result", result_data, 0);
    chk("rst_mid_spwd", sp_write_data, 0);
    reset = 1'b1;
    we_seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (sp_write_enable || !op_ready) we_seen = 1'b1;
    end
    chk("rst_mid_quiet", we_seen, 0);
    chk("rst_mid_sp", sp_reg, 2047);
    chk("rst_mid_orphan", mem[2047], 16'h0BAD);
    run_vec(mk(OP_PUSH16, 32'h00004321, -1, 0, 32'h0, 2046, 2, 1, 0, 2047, 16'h4321), 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_stack_engine
`default_nettype wire

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Memory-stage client of the stack-pointer register.
- Sequences PUSH/POP, CALL/RET and INT/RTI stack traffic over the 16-bit data memory.
- Reads the current SP, drives the SP register's write_data/write_enable with the updated value, and returns popped data to the pipeline.
- Stack grows downward from the SP reset value 2047.

Parameters:
- ADDR_W, 11, data-memory word-address width; mem_addr = SP[ADDR_W-1:0].
- STACK_TOP, 2047, highest stack address; the SP value of an empty stack.
- STACK_BASE, 1024, lowest address a push may write.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-low; reset=0 sampled at posedge clears the block.
- op_valid  in  1  stack operation request from the memory stage.
- op_code  in  2  0=PUSH16, 1=POP16, 2=PUSH32 (CALL/INT PC), 3=POP32 (RET/RTI PC).
- op_data  in  32  push data; PUSH16 uses [15:0].
- op_ready  out  1  high only in IDLE; the request is accepted when op_valid&op_ready at posedge.
- done  out  1  one-cycle pulse when the operation completes.
- err  out  1  one-cycle pulse with done on overflow/underflow.
- result_data  out  32  popped value, valid while done=1; POP16 is zero-extended.
- stall  out  1  ~op_ready; freezes earlier pipeline stages.
- sp_read_data  in  32  current SP register value.
- sp_write_data  out  32  new SP value.
- sp_write_enable  out  1  SP update strobe, high in DONE only when err=0.
- mem_addr  out  ADDR_W  stack memory word address.
- mem_wdata  out  16  write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe; mem_rdata is valid the cycle after.
- mem_rdata  in  16  memory read data, 1-cycle latency.

Behaviour:
- Moore FSM with states IDLE, WR_HI, WR_LO, RD_LO, RD_HI, RD_WAIT, DONE. All memory and SP outputs decode from the state and latched registers.
- On accept, latch op_code, op_data, and sp = sp_read_data. The bounds check uses the latched sp.
- Error check at accept:
  - PUSH16 errs if sp < STACK_BASE.
  - PUSH32 errs if sp < STACK_BASE+1.
  - POP16 errs if sp+1 > STACK_TOP.
  - POP32 errs if sp+2 > STACK_TOP.
  - On error: go IDLE->DONE directly with err=1. No memory access, no SP write, result_data=0.
- PUSH16: IDLE -> WR_LO (mem_write, addr=sp, wdata=data[15:0]) -> DONE (sp_write_data=sp-1) -> IDLE.
- PUSH32: IDLE -> WR_HI (addr=sp, data[31:16]) -> WR_LO (addr=sp-1, data[15:0]) -> DONE (sp-2).
- POP16: IDLE -> RD_LO (mem_read, addr=sp+1) -> RD_WAIT (capture rdata into result[15:0]) -> DONE (sp+1).
- POP32: IDLE -> RD_LO (addr=sp+1) -> RD_HI (addr=sp+2; capture low word) -> RD_WAIT (capture high word) -> DONE (sp+2).
- Latency is counted in cycles from the accept edge to the done edge:
  - PUSH16: 2.
  - PUSH32: 3.
  - POP16: 3.
  - POP32: 4.
  - Error: 1.
- DONE always returns to IDLE. Back-to-back ops therefore have one idle cycle with op_ready=1.
- Address arithmetic is 32-bit on the latched sp. mem_addr truncates to ADDR_W bits. With the checks passing, no wrap occurs.
- op_valid while busy is ignored; the requester must hold it. op_code/op_data changes while busy have no effect.
- Reset (reset=0 at posedge), including mid-operation:
  - Go to IDLE.
  - done, err, mem_write, mem_read and sp_write_enable are all 0.
  - result_data, mem_addr, mem_wdata and sp_write_data are 0.
  - op_ready=1 on the cycle after reset.
  - No SP write occurs for the aborted op. A PUSH32 aborted after WR_HI leaves one orphan word in memory, which is acceptable.
- SP register reset (to 2047) happens in the SP register itself on the same edge. The engine never writes SP during reset.

Decomposition:
- Shared header stack_defs.vh holds:
  - op codes OP_PUSH16/OP_POP16/OP_PUSH32/OP_POP32;
  - FSM state encodings;
  - STACK_TOP/STACK_BASE defaults.
- One natural sub-module: stack_bounds_check. It is combinational and maps (op_code, sp) to err, and is reused by the hazard unit.

Test Plan:
- After reset with SP=2047: PUSH32 0xDEAD_BEEF -> mem[2047]=0xDEAD, mem[2046]=0xBEEF, sp_write_data=2045 with done 3 cycles after accept, err=0.
- Then POP32 at SP=2045 -> reads addr 2046 then 2047, result_data=0xDEAD_BEEF, sp_write_data=2047, done 4 cycles after accept.
- POP16 at SP=2047 -> err=1 and done=1 one cycle after accept; no mem_read, no sp_write_enable.
- PUSH16 0x1234 at SP=STACK_BASE -> mem[1024]=0x1234, SP=1023. A following PUSH16 at SP=1023 -> err=1, no write.
- Hold op_valid across a PUSH32 -> second op accepted only after DONE (one IDLE cycle); stall=1 throughout busy.
- Assert reset=0 during WR_LO of PUSH32 -> next cycle IDLE, all strobes 0, no sp_write_enable, op_ready=1.
